// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame scheduler and its round-robin arbiter.
package fft_pkg;

   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_LOAD  = 5'b00010,
      S_WAIT  = 5'b00100,
      S_DRAIN = 5'b01000,
      S_GAP   = 5'b10000
   } state_e;

   // Counter/index width for a range of n values; never narrower than one bit.
   function automatic int unsigned cw(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, wrapping.
module rr_arbiter
   import fft_pkg::*;
#(
   parameter  int unsigned NUM_CH = 4,
   localparam int unsigned IW     = cw(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [IW-1:0]     ptr_i,
   input  logic              en_i,
   output logic [NUM_CH-1:0] grant_o,
   output logic [IW-1:0]     idx_o
);

   logic [IW-1:0] cand;
   logic          found;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         cand = IW'((32'(ptr_i) + i) % NUM_CH);
         if (en_i && !found && req_i[cand]) begin
            found         = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = cand;
         end
      end
   end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Shares one FFT core between NUM_CH frame sources: round-robin grant, burst load,
// result forwarding with channel tag, and a watchdog for a silent core.
module fft_frame_scheduler
   import fft_pkg::*;
#(
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned N_POINT        = 16,
   parameter int unsigned DATA_IN_WIDTH  = 16,
   parameter int unsigned DATA_OUT_WIDTH = 32,
   parameter int unsigned GAP_CYCLES     = 2,
   parameter int unsigned TIMEOUT        = 256
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             enable,
   input  logic [NUM_CH-1:0]                ch_req,
   input  logic [NUM_CH*DATA_IN_WIDTH-1:0]  ch_data,
   output logic [NUM_CH-1:0]                ch_pop,
   output logic [NUM_CH-1:0]                ch_grant,
   output logic [DATA_IN_WIDTH-1:0]         core_in_data,
   output logic                             core_in_valid,
   input  logic [DATA_OUT_WIDTH-1:0]        core_out_data,
   input  logic                             core_out_valid,
   output logic [DATA_OUT_WIDTH-1:0]        res_data,
   output logic                             res_valid,
   output logic [$clog2(NUM_CH)-1:0]        res_ch,
   output logic                             res_last,
   output logic                             busy,
   output logic                             timeout_err
);

   localparam int unsigned IW = cw(NUM_CH);
   localparam int unsigned CW = cw(N_POINT);
   localparam int unsigned WW = cw(TIMEOUT);
   localparam int unsigned GW = cw(GAP_CYCLES);

   state_e                     state_q;
   logic [IW-1:0]              gidx_q, ptr_q, ptr_d;
   logic [CW-1:0]              scnt_q, ocnt_q;
   logic [WW-1:0]              wd_q;
   logic [GW-1:0]              gcnt_q;
   logic [NUM_CH-1:0]          pop_q, grant_q;
   logic [DATA_IN_WIDTH-1:0]   cin_data_q;
   logic                       cin_valid_q;
   logic [DATA_OUT_WIDTH-1:0]  res_data_q;
   logic                       res_valid_q, res_last_q, tmo_q;
   logic [IW-1:0]              res_ch_q;
   logic [NUM_CH-1:0]          arb_grant;
   logic [IW-1:0]              arb_idx;
   logic [DATA_IN_WIDTH-1:0]   sel_data;

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .req_i   (ch_req),
      .ptr_i   (ptr_q),
      .en_i    (enable),
      .grant_o (arb_grant),
      .idx_o   (arb_idx)
   );

   assign ptr_d    = (gidx_q == IW'(NUM_CH - 1)) ? '0 : gidx_q + 1'b1;
   assign sel_data = ch_data[32'(gidx_q) * DATA_IN_WIDTH +: DATA_IN_WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         gidx_q      <= '0;
         ptr_q       <= '0;
         scnt_q      <= '0;
         ocnt_q      <= '0;
         wd_q        <= '0;
         gcnt_q      <= '0;
         pop_q       <= '0;
         grant_q     <= '0;
         cin_data_q  <= '0;
         cin_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         res_last_q  <= 1'b0;
         res_ch_q    <= '0;
         tmo_q       <= 1'b0;
      end else begin
         cin_valid_q <= 1'b0;
         res_valid_q <= 1'b0;
         res_last_q  <= 1'b0;
         tmo_q       <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (|arb_grant) begin
                  gidx_q  <= arb_idx;
                  grant_q <= arb_grant;
                  pop_q   <= arb_grant;
                  scnt_q  <= '0;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               cin_valid_q <= 1'b1;
               cin_data_q  <= sel_data;
               if (scnt_q == CW'(N_POINT - 1)) begin
                  pop_q   <= '0;
                  scnt_q  <= '0;
                  ocnt_q  <= '0;
                  wd_q    <= '0;
                  state_q <= S_WAIT;
               end else begin
                  scnt_q <= scnt_q + 1'b1;
               end
            end
            // WAIT and DRAIN share forwarding; the output count is still 0 in WAIT,
            // so the first result is counted exactly like any later one.
            S_WAIT, S_DRAIN: begin
               if (core_out_valid) begin
                  res_valid_q <= 1'b1;
                  res_data_q  <= core_out_data;
                  res_ch_q    <= gidx_q;
                  wd_q        <= '0;
                  if (ocnt_q == CW'(N_POINT - 1)) begin
                     res_last_q <= 1'b1;
                     ocnt_q     <= '0;
                     grant_q    <= '0;
                     ptr_q      <= ptr_d;
                     gcnt_q     <= '0;
                     state_q    <= S_GAP;
                  end else begin
                     ocnt_q  <= ocnt_q + 1'b1;
                     state_q <= S_DRAIN;
                  end
               end else if (wd_q == WW'(TIMEOUT - 1)) begin
                  tmo_q   <= 1'b1;
                  ocnt_q  <= '0;
                  grant_q <= '0;
                  ptr_q   <= ptr_d;
                  gcnt_q  <= '0;
                  state_q <= S_GAP;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            S_GAP: begin
               if (gcnt_q == GW'(GAP_CYCLES - 1)) begin
                  gcnt_q  <= '0;
                  state_q <= S_IDLE;
               end else begin
                  gcnt_q <= gcnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ch_pop        = pop_q;
   assign ch_grant      = grant_q;
   assign core_in_data  = cin_data_q;
   assign core_in_valid = cin_valid_q;
   assign res_data      = res_data_q;
   assign res_valid     = res_valid_q;
   assign res_ch        = res_ch_q;
   assign res_last      = res_last_q;
   assign busy          = (state_q != S_IDLE);
   assign timeout_err   = tmo_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Randomized bench for fft_frame_scheduler with frame-level reference model,
// FWFT source queues and an FFT core stand-in that returns 2x each sample.
module tb_fft_frame_scheduler;

   localparam int unsigned NUM_CH     = 4;
   localparam int unsigned N_POINT    = 16;
   localparam int unsigned DIW        = 16;
   localparam int unsigned DOW        = 32;
   localparam int unsigned GAP_CYCLES = 2;
   localparam int unsigned TIMEOUT    = 256;
   localparam int unsigned LAT        = 5;
   localparam int unsigned IW         = $clog2(NUM_CH);

   logic                    clk, rst_n, enable;
   logic [NUM_CH-1:0]       ch_req, ch_pop, ch_grant;
   logic [NUM_CH*DIW-1:0]   ch_data;
   logic [DIW-1:0]          core_in_data;
   logic                    core_in_valid;
   logic [DOW-1:0]          core_out_data;
   logic                    core_out_valid;
   logic [DOW-1:0]          res_data;
   logic                    res_valid, res_last, busy, timeout_err;
   logic [IW-1:0]           res_ch;

   fft_frame_scheduler #(
      .NUM_CH         (NUM_CH),
      .N_POINT        (N_POINT),
      .DATA_IN_WIDTH  (DIW),
      .DATA_OUT_WIDTH (DOW),
      .GAP_CYCLES     (GAP_CYCLES),
      .TIMEOUT        (TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .ch_req         (ch_req),
      .ch_data        (ch_data),
      .ch_pop         (ch_pop),
      .ch_grant       (ch_grant),
      .core_in_data   (core_in_data),
      .core_in_valid  (core_in_valid),
      .core_out_data  (core_out_data),
      .core_out_valid (core_out_valid),
      .res_data       (res_data),
      .res_valid      (res_valid),
      .res_ch         (res_ch),
      .res_last       (res_last),
      .busy           (busy),
      .timeout_err    (timeout_err)
   );

   typedef struct { int unsigned cyc; logic [DOW-1:0] data; } core_ev_t;
   typedef struct { logic [DOW-1:0] data; int unsigned ch; logic last; } res_ev_t;

   logic [DIW-1:0] src_q   [NUM_CH][$];
   logic [DIW-1:0] exp_smp [NUM_CH][$];
   int unsigned    m_pend  [NUM_CH];
   int unsigned    m_ptr;
   res_ev_t        exp_res [$];
   core_ev_t       core_q  [$];
   logic [DIW-1:0] core_buf[$];

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   logic [NUM_CH-1:0] pop_s;
   bit          in_burst, have_prev, cur_silent, cur_gap;
   int          cur_ch, pick_c;
   int unsigned cur_idx, pop_cnt, last_valid_cyc, exp_to_cyc;
   int unsigned silent_left, gap_left;
   logic [DIW-1:0] e_smp;
   res_ev_t     r;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int pick();
      for (int i = 0; i < int'(NUM_CH); i++) begin
         int c;
         c = (int'(m_ptr) + i) % int'(NUM_CH);
         if (m_pend[c] > 0) return c;
      end
      return -1;
   endfunction

   function automatic logic [63:0] out_vec();
      return {1'b0, ch_pop, ch_grant, core_in_data, core_in_valid, res_data,
              res_valid, res_ch, res_last, busy, timeout_err};
   endfunction

   function automatic bit quiet();
      int unsigned s = 0;
      for (int k = 0; k < int'(NUM_CH); k++) s += m_pend[k];
      return exp_res.size() == 0 && core_q.size() == 0 && s == 0 && !in_burst &&
             exp_to_cyc == 0 && !busy;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sources and core stand-in: update inputs 1 time unit after the edge.
   always begin
      @(posedge clk);
      cyc++;
      #1;
      for (int k = 0; k < int'(NUM_CH); k++) begin
         if (pop_s[k] && src_q[k].size() > 0) src_q[k].delete(0);
         ch_req[k] = (src_q[k].size() >= N_POINT);
         ch_data[k*DIW +: DIW] = (src_q[k].size() > 0) ? src_q[k][0] : '0;
      end
      if (core_q.size() > 0 && core_q[0].cyc == cyc) begin
         core_out_valid = 1'b1;
         core_out_data  = core_q[0].data;
         core_q.delete(0);
      end else begin
         core_out_valid = 1'b0;
         core_out_data  = $urandom;
      end
   end

   // Reference model and monitor, sampled on the falling edge.
   always @(negedge clk) begin
      pop_s = ch_pop;
      if (rst_n) begin
         if (ch_pop != '0) pop_cnt++;
         if (core_in_valid) begin
            if (!in_burst) begin
               pick_c = pick();
               if (pick_c < 0) begin
                  check("frame_expected", 0, 1);
                  pick_c = 0;
               end else begin
                  m_pend[pick_c]--;
               end
               cur_ch = pick_c;
               check("grant", ch_grant, 64'(1) << cur_ch);
               if (have_prev) check("gap_ok", 64'((cyc - last_valid_cyc - 1) >= GAP_CYCLES), 1);
               cur_silent = (silent_left > 0);
               if (cur_silent) silent_left--;
               cur_gap = (gap_left > 0);
               if (cur_gap) gap_left--;
               in_burst = 1'b1;
               cur_idx  = 0;
               core_buf.delete();
            end
            e_smp = '0;
            if (exp_smp[cur_ch].size() > 0) begin
               e_smp = exp_smp[cur_ch][0];
               exp_smp[cur_ch].delete(0);
            end
            check("core_in", core_in_data, e_smp);
            if (!cur_silent) exp_res.push_back('{DOW'(e_smp) << 1, cur_ch, cur_idx == N_POINT - 1});
            core_buf.push_back(core_in_data);
            cur_idx++;
            last_valid_cyc = cyc;
         end else if (in_burst) begin
            check("burst_len", cur_idx, N_POINT);
            check("pop_cnt", pop_cnt, N_POINT);
            pop_cnt   = 0;
            in_burst  = 1'b0;
            have_prev = 1'b1;
            m_ptr     = (cur_ch + 1) % NUM_CH;
            if (cur_silent) begin
               exp_to_cyc = last_valid_cyc + TIMEOUT;
            end else begin
               for (int i = 0; i < core_buf.size(); i++)
                  core_q.push_back('{last_valid_cyc + LAT + i +
                                     ((cur_gap && i >= int'(N_POINT / 2)) ? 3 : 0),
                                     DOW'(core_buf[i]) << 1});
            end
         end
         if (res_valid) begin
            if (exp_res.size() == 0) begin
               check("res_spurious", 1, 0);
            end else begin
               r = exp_res[0];
               exp_res.delete(0);
               check("res_data", res_data, r.data);
               check("res_ch", res_ch, r.ch);
               check("res_last", res_last, r.last);
            end
         end
         if (exp_to_cyc != 0 && cyc == exp_to_cyc) begin
            check("timeout_pulse", timeout_err, 1);
            exp_to_cyc = 0;
         end else if (timeout_err) begin
            check("timeout_spurious", 1, 0);
         end
      end
   end

   task automatic clear_model();
      for (int k = 0; k < int'(NUM_CH); k++) begin
         src_q[k].delete();
         exp_smp[k].delete();
         m_pend[k] = 0;
      end
      exp_res.delete();
      core_q.delete();
      core_buf.delete();
      m_ptr = 0; in_burst = 0; have_prev = 0; pop_cnt = 0; exp_to_cyc = 0;
      silent_left = 0; gap_left = 0; cur_ch = 0; cur_idx = 0;
   endtask

   task automatic push_frame(input int ch, input bit ramp);
      logic [DIW-1:0] v;
      for (int i = 0; i < int'(N_POINT); i++) begin
         v = ramp ? DIW'(i + 1) : DIW'($urandom);
         src_q[ch].push_back(v);
         exp_smp[ch].push_back(v);
      end
      m_pend[ch]++;
   endtask

   task automatic wait_quiet(input string tag, input int budget);
      int n = 0;
      bit q;
      do begin
         @(negedge clk); #1;
         q = quiet();
         n++;
      end while (!q && n < budget);
      check(tag, q, 1);
   endtask

   task automatic async_reset_pulse();
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1 check("rst_outputs", out_vec(), 0);
      clear_model();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("rst_busy", busy, 0);
   endtask

   initial begin
      int n;
      bit seen;
      rst_n = 1'b1; enable = 1'b0; ch_req = '0; ch_data = '0;
      core_out_valid = 1'b0; core_out_data = '0; pop_s = '0;
      clear_model();
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", out_vec(), 0);
      @(posedge clk); #2 rst_n = 1'b1;

      // All four channels requesting, channel 0 holding two frames.
      push_frame(0, 0); push_frame(0, 0);
      for (int k = 1; k < int'(NUM_CH); k++) push_frame(k, 0);
      @(posedge clk); #1 enable = 1'b1;
      wait_quiet("quiet_rr", 3000);

      // Single channel ramp 1..16.
      push_frame(0, 1);
      wait_quiet("quiet_ramp", 1000);

      // Silent core on the first frame, next requester served afterwards.
      silent_left = 1;
      push_frame(1, 0); push_frame(2, 0);
      wait_quiet("quiet_timeout", 2000);

      // Result burst with a 3-cycle valid gap in the middle.
      gap_left = 1;
      push_frame(1, 0);
      wait_quiet("quiet_gap", 1000);

      // enable dropped during LOAD of channel 2.
      @(posedge clk); #1 enable = 1'b0;
      push_frame(2, 0); push_frame(3, 0);
      @(posedge clk); #1 enable = 1'b1;
      n = 0;
      while (!ch_grant[2] && n < 200) begin @(negedge clk); n++; end
      check("grant2_seen", ch_grant[2], 1);
      repeat (3) @(posedge clk);
      #1 enable = 1'b0;
      n = 0;
      while (busy && n < 400) begin @(negedge clk); n++; end
      check("frame2_done", busy, 0);
      seen = 0;
      repeat (20) begin @(negedge clk); if (ch_grant != '0 || busy) seen = 1; end
      check("no_grant_disabled", seen, 0);
      @(posedge clk); #1 enable = 1'b1;
      @(negedge clk); check("grant_same_cycle", ch_grant, 0);
      @(negedge clk); check("grant_resume", ch_grant, 4'b1000);
      wait_quiet("quiet_enable", 1000);

      // Randomized request mixes.
      for (int rnd = 0; rnd < 4; rnd++) begin
         int tot = 0;
         for (int k = 0; k < int'(NUM_CH); k++) begin
            int nf = $urandom_range(0, 2);
            for (int f = 0; f < nf; f++) push_frame(k, 0);
            tot += nf;
         end
         if (tot == 0) push_frame($urandom_range(0, NUM_CH - 1), 0);
         gap_left = $urandom_range(0, 1);
         wait_quiet("quiet_random", 4000);
      end

      // Asynchronous reset while draining results.
      push_frame(3, 0);
      n = 0;
      while (!res_valid && n < 200) begin @(negedge clk); n++; end
      check("drain_reached", res_valid, 1);
      async_reset_pulse();
      for (int k = 0; k < int'(NUM_CH); k++) push_frame(k, 0);
      wait_quiet("quiet_after_reset", 3000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
- Shares one N_POINT FFT core between NUM_CH sample sources.
- Arbitrates frame requests round-robin and streams the granted channel's N_POINT samples into the core as one contiguous valid burst.
- Waits for the core's result burst and forwards it tagged with channel id and last flag.
- A watchdog recovers if the core never answers.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8)
- N_POINT, 16, samples per frame; power of two
- DATA_IN_WIDTH, 16, sample width
- DATA_OUT_WIDTH, 32, core result width
- GAP_CYCLES, 2, minimum core_in_valid low cycles between frames (≥1; the core starts on a valid rising edge)
- TIMEOUT, 256, max cycles from last loaded sample to first core_out_valid

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  when 0, no new grant is issued; the frame in flight completes
- ch_req  in  NUM_CH  per channel: a full frame is available (FWFT source)
- ch_data  in  NUM_CH*DATA_IN_WIDTH  packed sample heads; channel k at [k*W +: W]
- ch_pop  out  NUM_CH  one-hot; pops the granted channel's head this cycle
- ch_grant  out  NUM_CH  one-hot; owner of the current frame
- core_in_data  out  DATA_IN_WIDTH  sample to FFT core
- core_in_valid  out  1  sample valid to FFT core
- core_out_data  in  DATA_OUT_WIDTH  FFT result
- core_out_valid  in  1  FFT result valid
- res_data  out  DATA_OUT_WIDTH  registered result
- res_valid  out  1  result valid
- res_ch  out  $clog2(NUM_CH)  channel tag of the result
- res_last  out  1  final result of the frame
- busy  out  1  state != IDLE
- timeout_err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset: every output is 0. State IDLE, round-robin pointer = 0, all counters 0.
- IDLE:
  - If enable and (ch_req != 0): pick the first requesting channel at or after the pointer, wrapping.
  - Latch the winner in a grant register; go to LOAD the next cycle.
  - ch_grant asserts in LOAD.
- LOAD:
  - Exactly N_POINT cycles with ch_pop[g]=1 and core_in_valid=1.
  - core_in_data is ch_data[g], registered; core_in_valid/core_in_data lag ch_pop by 1 cycle.
  - Sample counter runs 0..N_POINT-1; at N_POINT-1 go to WAIT.
  - ch_req dropping mid-frame is ignored; the source guarantees a whole frame.
- WAIT:
  - Watchdog counter increments each cycle.
  - On core_out_valid go to DRAIN; that sample is already forwarded.
  - If the counter reaches TIMEOUT-1 first: pulse timeout_err, go to GAP.
- DRAIN:
  - Each core_out_valid cycle forwards the result; res_* is registered 1 cycle after core_out_*.
  - res_ch = g. res_last = 1 on output count N_POINT-1, then go to GAP.
  - core_out_valid low mid-burst: hold and do not count; the watchdog restarts and applies as in WAIT.
- GAP:
  - GAP_CYCLES cycles with core_in_valid=0.
  - Pointer = g+1 mod NUM_CH (updated on both the normal and timeout path).
  - ch_grant clears; return to IDLE.
- Fairness: a channel continuously requesting is served within NUM_CH frames.
- enable falling during LOAD/WAIT/DRAIN does not abort the frame.
- core_out_valid outside WAIT/DRAIN is ignored; res_valid stays 0.
- Back-to-back frames: minimum period = 1 (arb) + N_POINT + core latency + N_POINT + GAP_CYCLES.
- Widths: sample counter and output counter are $clog2(N_POINT) bits, compared to N_POINT-1; watchdog is $clog2(TIMEOUT) bits.
- No arithmetic on data; pure muxing and registering.

Decomposition:
- Shared package fft_pkg:
  - State encoding constants: one-hot IDLE/LOAD/WAIT/DRAIN/GAP.
  - clog2-derived width constants for counters and channel id.
- Sub-module rr_arbiter (NUM_CH):
  - Inputs: req, pointer, enable.
  - Outputs: one-hot grant and its index, combinational.
  - Reused by other shared-resource controllers.

Test Plan:
- Single channel: ch_req=0001, ch_data ramp 1..16, core model echoes input×2 after 5 cycles.
  - Expect 16 core_in_valid cycles carrying 1..16 in order.
  - Expect res_data 2..32 with res_ch=0 and res_last on the 16th.
- All four channels request continuously.
  - Expect grant order 0,1,2,3,0.
  - Expect ≥2 core_in_valid low cycles between bursts.
  - Expect ch_pop count per frame = 16.
- Core model never asserts core_out_valid.
  - Expect timeout_err single pulse exactly TIMEOUT cycles after the last LOAD sample.
  - Expect a return to IDLE, pointer advanced, and the next requester served.
- enable dropped during LOAD of channel 2.
  - Expect the frame to complete with res_ch=2 and no new grant while enable=0.
  - Expect the grant to resume on the cycle after enable returns high.
- rst_n asserted in DRAIN: all outputs 0 immediately (async); after release, state is IDLE and pointer is 0.
- Core result burst with 3-cycle valid gap mid-frame: expect 16 results still counted, res_last on the true 16th, no timeout.
